// File: rtl/axi4_mul_scheduler.sv
// axi4_mul_scheduler: AXI4 master that lets two requesters share one link to
// the multiplier slave. Jobs are granted round-robin and run one at a time:
// operand A write burst, operand B write burst, result read burst, response.
// Optional watchdog: define AXI4_SCHED_TIMEOUT_EN to abort stuck jobs after
// TMO_CYC idle cycles (response then carries rsp_err=1, rsp_res=0).
module axi4_mul_scheduler #(
  parameter int SZ      = 32,
  parameter int DSZ     = 8,
  parameter int ASZ     = 2,
  parameter int TMO_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*SZ-1:0]   req_a,
  input  logic [2*SZ-1:0]   req_b,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [2*SZ-1:0]   rsp_res,
  output logic              rsp_err,
  output logic [ASZ-1:0]    awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DSZ-1:0]    wdata,
  output logic              wvalid,
  input  logic              wready,
  output logic              wlast,
  input  logic              bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [ASZ-1:0]    araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DSZ-1:0]    rdata,
  input  logic              rvalid,
  output logic              rready,
  input  logic              rlast,
  input  logic              rresp
);

  localparam int OBEATS = SZ / DSZ;
  localparam int RBEATS = 2 * SZ / DSZ;
  localparam int BW     = $clog2(RBEATS) + 1;
  localparam logic [BW-1:0] OB_LAST = BW'(OBEATS - 1);
  localparam logic [BW-1:0] RB_LAST = BW'(RBEATS - 1);

  // Reject parameter sets the burst framing cannot represent.
  if (SZ % DSZ != 0) begin : g_bad_sz
    $error("axi4_mul_scheduler: SZ must be a multiple of DSZ");
  end
  if (TMO_CYC < 2) begin : g_bad_tmo
    $error("axi4_mul_scheduler: TMO_CYC must be at least 2");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_AW_A, S_W_A, S_B_A, S_AW_B, S_W_B, S_B_B, S_AR, S_R, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic            last_grant;
  logic            gnt_id;
  logic            start;
  logic            g_q;
  logic [SZ-1:0]   b_q;
  logic [SZ-1:0]   wsh_q;
  logic [2*SZ-1:0] res_q;
  logic [BW-1:0]   beat;
  logic            err_q;
  logic            w_hs, r_hs, b_hs;
  logic            w_last_beat, r_last_beat;

`ifdef AXI4_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_q;
  logic            tmo_hit;

  assign tmo_hit = (state != S_IDLE) && (state != S_DONE) &&
                   (tmo_cnt == TW'(TMO_CYC - 1));
`endif

  // Round-robin: with both requesters pending, the one not served last wins.
  assign gnt_id = (&req_valid) ? ~last_grant : req_valid[1];
  assign start  = (state == S_IDLE) && (|req_valid) && !rst;

  assign w_hs        = wvalid & wready;
  assign r_hs        = rvalid & rready;
  assign b_hs        = bvalid & bready;
  assign w_last_beat = (beat == OB_LAST);
  assign r_last_beat = (beat == RB_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; each channel waits for its own handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start)                state_nxt = S_AW_A;
      S_AW_A: if (awready)              state_nxt = S_W_A;
      S_W_A:  if (wready && w_last_beat) state_nxt = S_B_A;
      S_B_A:  if (bvalid)               state_nxt = S_AW_B;
      S_AW_B: if (awready)              state_nxt = S_W_B;
      S_W_B:  if (wready && w_last_beat) state_nxt = S_B_B;
      S_B_B:  if (bvalid)               state_nxt = S_AR;
      S_AR:   if (arready)              state_nxt = S_R;
      S_R:    if (rvalid && r_last_beat) state_nxt = S_DONE;
      S_DONE:                           state_nxt = S_IDLE;
      default:                          state_nxt = S_IDLE;
    endcase
`ifdef AXI4_SCHED_TIMEOUT_EN
    if (tmo_hit) state_nxt = S_DONE;
`endif
  end

  // Channel outputs decoded from the state; only one channel is live at a time.
  always_comb begin
    req_ready = 2'b00;
    awvalid   = 1'b0;
    awaddr    = '0;
    wvalid    = 1'b0;
    wlast     = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    araddr    = '0;
    rready    = 1'b0;
    case (state)
      S_IDLE: if (start) req_ready = gnt_id ? 2'b10 : 2'b01;
      S_AW_A: awvalid = 1'b1;
      S_AW_B: begin
        awvalid = 1'b1;
        awaddr  = ASZ'(1);
      end
      S_W_A, S_W_B: begin
        wvalid = 1'b1;
        wlast  = w_last_beat;
      end
      S_B_A, S_B_B: bready = 1'b1;
      S_AR: begin
        arvalid = 1'b1;
        araddr  = ASZ'(2);
      end
      S_R: rready = 1'b1;
      default: ;
    endcase
  end

  // The write beat is always the low slice of the shifting operand register.
  assign wdata = wsh_q[DSZ-1:0];

  // Arbitration memory and beat counter; the counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      beat       <= '0;
    end else begin
      if (start) last_grant <= gnt_id;
      if (state_nxt != state)  beat <= '0;
      else if (w_hs || r_hs)   beat <= beat + BW'(1);
    end
  end

  // Operand capture and write shifter: A goes out first, B is loaded after A's last beat.
  always_ff @(posedge clk) begin
    if (start) begin
      g_q   <= gnt_id;
      wsh_q <= gnt_id ? req_a[2*SZ-1:SZ] : req_a[SZ-1:0];
      b_q   <= gnt_id ? req_b[2*SZ-1:SZ] : req_b[SZ-1:0];
    end else if (w_hs && w_last_beat && state == S_W_A) begin
      wsh_q <= b_q;
    end else if (w_hs) begin
      wsh_q <= wsh_q >> DSZ;
    end
  end

  // Result assembly: beats arrive LSB first, so shift each new beat in from the top.
  always_ff @(posedge clk) begin
    if (r_hs) res_q <= {rdata, res_q[2*SZ-1:DSZ]};
  end

  // Sticky job error: bad write/read response or rlast not exactly on the final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (start) begin
      err_q <= 1'b0;
    end else begin
      if (b_hs && !bresp) err_q <= 1'b1;
      if (r_hs && (!rresp || (rlast != r_last_beat))) err_q <= 1'b1;
    end
  end

`ifdef AXI4_SCHED_TIMEOUT_EN
  // Watchdog: restarts on any progress, latches a timeout flag for the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      if (state_nxt != state || w_hs || r_hs) tmo_cnt <= '0;
      else if (state != S_IDLE)               tmo_cnt <= tmo_cnt + TW'(1);
      if (start)        tmo_q <= 1'b0;
      else if (tmo_hit) tmo_q <= 1'b1;
    end
  end
`endif

  // Response register: a one-cycle pulse issued as DONE is left.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_res   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= (state == S_DONE);
      if (state == S_DONE) begin
        rsp_id <= g_q;
`ifdef AXI4_SCHED_TIMEOUT_EN
        rsp_res <= tmo_q ? '0 : res_q;
        rsp_err <= err_q | tmo_q;
`else
        rsp_res <= res_q;
        rsp_err <= err_q;
`endif
      end
    end
  end

endmodule

// File: doc/axi4_mul_scheduler.md
Name: axi4_mul_scheduler

Overview:
- Master-side scheduler that lets two requesters share one AXI4 link to the multiplier slave (slave wrapper, address map below).
- Round-robin arbitration between the two requesters; one job at a time.
- Each job runs in order: operand A write burst, operand B write burst, then the result read burst. Returns the product, requester id and error flag.
- Replaces direct a/b/res drive of the link; sits between client logic and the slave's AXI4 channels.

Parameters:
- SZ, 32, operand width; result is 2*SZ. SZ must be a multiple of DSZ.
- DSZ, 8, AXI data width; operand burst = SZ/DSZ beats, result burst = 2*SZ/DSZ beats.
- ASZ, 2, address width. Address map: 0 = operand A, 1 = operand B, 2 = result.
- TMO_CYC, 64, watchdog limit in cycles (optional feature only).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  bit i: requester i has a job.
- req_ready  out  2  bit i: job i accepted this cycle (one-hot, at most one bit).
- req_a  in  2*SZ  operand A; requester i in bits [i*SZ +: SZ].
- req_b  in  2*SZ  operand B; same packing as req_a.
- rsp_valid  out  1  one-cycle result pulse.
- rsp_id  out  1  requester the result belongs to.
- rsp_res  out  2*SZ  product.
- rsp_err  out  1  1 = bad response, rlast mismatch or timeout.
- awaddr/awvalid/awready  out/out/in  ASZ/1/1  write-address channel.
- wdata/wvalid/wready/wlast  out/out/in/out  DSZ/1/1/1  write-data channel.
- bresp/bvalid/bready  in/in/out  1/1/1  write response; bresp=1 means OK.
- araddr/arvalid/arready  out/out/in  ASZ/1/1  read-address channel.
- rdata/rvalid/rready/rlast/rresp  in/in/out/in/in  DSZ/1/1/1/1  read-data channel; rresp=1 means OK.

Behaviour:
- Reset:
  - All valid/ready outputs 0, rsp_res=0, rsp_id=0, rsp_err=0.
  - State IDLE; last_grant=1, so requester 0 wins first.
  - Reset mid-burst: all channel valids drop at that edge; the job is discarded and no rsp is issued.
- IDLE arbitration:
  - If any req_valid, grant via round-robin: when both are valid, grant the requester != last_grant.
  - req_ready[g]=1 combinationally in IDLE; at that edge latch a, b and g, update last_grant, clear the error flag, go to AW_A.
- States: IDLE -> AW_A -> W_A -> B_A -> AW_B -> W_B -> B_B -> AR -> R -> DONE -> IDLE.
- AW_x:
  - awvalid=1, awaddr = 0 (A) or 1 (B).
  - Hold awvalid and awaddr stable until awready.
  - On the handshake go to W_x.
- W_x:
  - wvalid=1, SZ/DSZ beats, LSB byte first, beat counter advances only on wvalid&wready.
  - wlast=1 on the final beat only; wdata stable while stalled.
  - After the last-beat handshake go to B_x.
- B_x:
  - bready=1.
  - On bvalid: bresp=0 sets the error flag; advance regardless.
- AR:
  - arvalid=1, araddr=2, held until arready.
- R:
  - rready=1, 2*SZ/DSZ beats, assembled LSB beat first into rsp_res.
  - rresp=0 on any beat sets the error flag.
  - rlast must be 1 exactly on the final beat; otherwise set the error flag.
  - The burst always ends by beat count, not by rlast.
- DONE:
  - rsp_valid=1 for one cycle, with rsp_id, rsp_res and rsp_err.
  - Return to IDLE; a new grant is possible the following cycle.
- General rules:
  - No AXI valid is ever dropped before its handshake.
  - Only one channel is active at a time.
  - req_ready is 0 outside IDLE.
- Latency with a zero-wait slave (SZ=32, DSZ=8): rsp_valid is 22 cycles after the req handshake edge.
- Requester i holding req_valid while the other job runs is served next; starvation is impossible.

Optional Feature:
- Macro AXI4_SCHED_TIMEOUT_EN.
- When defined:
  - A watchdog counter resets on every state change and every beat handshake.
  - If it reaches TMO_CYC in any non-IDLE state, all channel valids and readies drop and the FSM goes to DONE.
  - DONE then issues rsp_err=1 and rsp_res=0.
- When undefined: no counter; the FSM waits indefinitely.

Test Plan:
- Zero-wait slave, req0 a=5 b=7 -> rsp_valid with rsp_id=0, rsp_res=35, rsp_err=0, 22 cycles after the handshake; wlast on beats 4 and 8, araddr=2.
- req0 (5,7) and req1 (17,31) both valid at the same cycle -> req0 served first (res 35), then req1 (res 527); then with both re-asserted, req1 is not granted twice in a row.
- Slave deasserts wready every other cycle and delays arready 5 cycles -> wdata/awaddr stable while stalled, result still 527, no beats lost.
- bresp=0 on operand B write -> job completes all bursts, rsp_err=1; next job (5,7) returns 35 with err=0.
- rlast asserted on read beat 6 of 8 -> rsp_err=1; rst pulsed during W_A -> all valids 0 next cycle, no rsp_valid, next job correct.
- With AXI4_SCHED_TIMEOUT_EN, slave never asserts awready -> rsp_err=1, rsp_res=0 after TMO_CYC=64 cycles, FSM back in IDLE.
